// File: rtl/gray_wptr_ctrl.sv
// Write-side pointer controller for an async FIFO: binary/Gray write pointer, read-pointer synchroniser, registered full.
// Optional registered almost_full output when GRAY_WPTR_ALMOST_FULL_EN is defined.
module gray_wptr_ctrl #(
  parameter int unsigned ADDR_WIDTH  = 4,
  parameter int unsigned SYNC_STAGES = 2
`ifdef GRAY_WPTR_ALMOST_FULL_EN
  ,
  parameter int unsigned AF_THRESH   = 12
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_req,
  output logic                  wr_ack,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [ADDR_WIDTH:0]   wr_gray,
  input  logic [ADDR_WIDTH:0]   rd_gray_async,
  output logic                  full
`ifdef GRAY_WPTR_ALMOST_FULL_EN
  ,
  output logic                  almost_full
`endif
);

  localparam int unsigned PW = ADDR_WIDTH + 1;

  logic [PW-1:0] wr_bin;
  logic [PW-1:0] wr_bin_next;
  logic [PW-1:0] wr_gray_next;
  logic [PW-1:0] rd_sync;
  logic [PW-1:0] full_target;
  logic [PW-1:0] sync_q [SYNC_STAGES];
  logic          push;
  logic          full_next;

  // rst_n gates the handshake so ack/en drop the instant reset asserts.
  assign push    = wr_req & ~full & rst_n;
  assign wr_ack  = push;
  assign wr_en   = push;
  assign wr_addr = wr_bin[ADDR_WIDTH-1:0];
  assign rd_sync = sync_q[SYNC_STAGES-1];

  always_comb begin
    wr_bin_next  = wr_bin + {{ADDR_WIDTH{1'b0}}, push};
    wr_gray_next = wr_bin_next ^ (wr_bin_next >> 1);
    full_target  = {~rd_sync[PW-1:PW-2], rd_sync[PW-3:0]};
    full_next    = (wr_gray_next == full_target);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= rd_gray_async;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bin  <= '0;
      wr_gray <= '0;
      full    <= 1'b0;
    end else begin
      wr_bin  <= wr_bin_next;
      wr_gray <= wr_gray_next;
      full    <= full_next;
    end
  end

`ifdef GRAY_WPTR_ALMOST_FULL_EN
  logic [PW-1:0] rd_bin;
  logic [PW-1:0] level_next;

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    rd_bin = rd_sync;
    for (int unsigned i = 1; i < PW; i++) begin
      rd_bin = rd_bin ^ (rd_sync >> i);
    end
    level_next = wr_bin_next - rd_bin;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      almost_full <= 1'b0;
    end else begin
      almost_full <= (level_next >= PW'(AF_THRESH));
    end
  end
`endif

endmodule

// File: tb/tb_gray_wptr_ctrl.sv
// Directed, table-driven bench for gray_wptr_ctrl at ADDR_WIDTH=4, SYNC_STAGES=2.
module tb_gray_wptr_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_req;
  logic       wr_ack;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [4:0] wr_gray;
  logic [4:0] rd_gray_async;
  logic       full;
`ifdef GRAY_WPTR_ALMOST_FULL_EN
  logic       almost_full;
`endif

  gray_wptr_ctrl #(
    .ADDR_WIDTH (4),
    .SYNC_STAGES(2)
`ifdef GRAY_WPTR_ALMOST_FULL_EN
    ,
    .AF_THRESH  (12)
`endif
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_req       (wr_req),
    .wr_ack       (wr_ack),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_gray      (wr_gray),
    .rd_gray_async(rd_gray_async),
    .full         (full)
`ifdef GRAY_WPTR_ALMOST_FULL_EN
    ,
    .almost_full  (almost_full)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       req;
    logic       ack;
    logic [4:0] gray;
    logic [3:0] addr;
    logic       full;
  } vec_t;

  vec_t tv [17];

  logic [4:0] b;
  logic [4:0] g;
  logic [4:0] pg;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tv[0]  = '{1'b1, 1'b1, 5'b00001, 4'd1,  1'b0};
    tv[1]  = '{1'b1, 1'b1, 5'b00011, 4'd2,  1'b0};
    tv[2]  = '{1'b1, 1'b1, 5'b00010, 4'd3,  1'b0};
    tv[3]  = '{1'b1, 1'b1, 5'b00110, 4'd4,  1'b0};
    tv[4]  = '{1'b1, 1'b1, 5'b00111, 4'd5,  1'b0};
    tv[5]  = '{1'b1, 1'b1, 5'b00101, 4'd6,  1'b0};
    tv[6]  = '{1'b1, 1'b1, 5'b00100, 4'd7,  1'b0};
    tv[7]  = '{1'b1, 1'b1, 5'b01100, 4'd8,  1'b0};
    tv[8]  = '{1'b1, 1'b1, 5'b01101, 4'd9,  1'b0};
    tv[9]  = '{1'b1, 1'b1, 5'b01111, 4'd10, 1'b0};
    tv[10] = '{1'b1, 1'b1, 5'b01110, 4'd11, 1'b0};
    tv[11] = '{1'b1, 1'b1, 5'b01010, 4'd12, 1'b0};
    tv[12] = '{1'b1, 1'b1, 5'b01011, 4'd13, 1'b0};
    tv[13] = '{1'b1, 1'b1, 5'b01001, 4'd14, 1'b0};
    tv[14] = '{1'b1, 1'b1, 5'b01000, 4'd15, 1'b0};
    tv[15] = '{1'b1, 1'b1, 5'b11000, 4'd0,  1'b1};
    tv[16] = '{1'b1, 1'b0, 5'b11000, 4'd0,  1'b1};

    rst_n = 1'b0;
    wr_req = 1'b0;
    rd_gray_async = 5'b00000;
    #12;
    chk("rst_gray", 32'(wr_gray), 32'h0);
    chk("rst_addr", 32'(wr_addr), 32'h0);
    chk("rst_full", 32'(full), 32'h0);
    chk("rst_ack", 32'(wr_ack), 32'h0);
`ifdef GRAY_WPTR_ALMOST_FULL_EN
    chk("rst_af", 32'(almost_full), 32'h0);
`endif
    rst_n = 1'b1;
    tick();

    // Asynchronous reset in the middle of a burst
    wr_req = 1'b1;
    tick(); tick(); tick();
    chk("burst3_gray", 32'(wr_gray), 32'h02);
    chk("burst3_addr", 32'(wr_addr), 32'h3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_gray", 32'(wr_gray), 32'h0);
    chk("midrst_addr", 32'(wr_addr), 32'h0);
    chk("midrst_full", 32'(full), 32'h0);
    chk("midrst_ack", 32'(wr_ack), 32'h0);
    chk("midrst_en", 32'(wr_en), 32'h0);
    wr_req = 1'b0;
    rst_n = 1'b1;
    tick();

    // Fill from empty: 16 pushes, then a dropped 17th request
    for (int i = 0; i < 17; i++) begin
      wr_req = tv[i].req;
      #1;
      chk($sformatf("fill%0d_ack", i), 32'(wr_ack), 32'(tv[i].ack));
      chk($sformatf("fill%0d_en", i), 32'(wr_en), 32'(tv[i].ack));
      tick();
      chk($sformatf("fill%0d_gray", i), 32'(wr_gray), 32'(tv[i].gray));
      chk($sformatf("fill%0d_addr", i), 32'(wr_addr), 32'(tv[i].addr));
      chk($sformatf("fill%0d_full", i), 32'(full), 32'(tv[i].full));
`ifdef GRAY_WPTR_ALMOST_FULL_EN
      chk($sformatf("fill%0d_af", i), 32'(almost_full), (i >= 11) ? 32'h1 : 32'h0);
`endif
    end
    wr_req = 1'b0;

    // Full release latency through the two-flop synchroniser
    rd_gray_async = 5'b00001;
    tick();
    chk("rel_e1_full", 32'(full), 32'h1);
    tick();
    chk("rel_e2_full", 32'(full), 32'h1);
    tick();
    chk("rel_e3_full", 32'(full), 32'h0);
    wr_req = 1'b1;
    #1;
    chk("refill_ack", 32'(wr_ack), 32'h1);
    tick();
    chk("refill_gray", 32'(wr_gray), 32'h19);
    chk("refill_full", 32'(full), 32'h1);
    #1;
    chk("refill_drop_ack", 32'(wr_ack), 32'h0);

    // Reset while full and requesting
    #1;
    rst_n = 1'b0;
    #1;
    chk("fullrst_full", 32'(full), 32'h0);
    chk("fullrst_gray", 32'(wr_gray), 32'h0);
    chk("fullrst_ack", 32'(wr_ack), 32'h0);
    wr_req = 1'b0;
    rd_gray_async = 5'b00000;
    rst_n = 1'b1;
    tick();

    // 15 held; push on the first cycle the freed slot is visible in rd_sync
    wr_req = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    chk("h15_gray", 32'(wr_gray), 32'h08);
    chk("h15_full", 32'(full), 32'h0);
    wr_req = 1'b0;
    rd_gray_async = 5'b00001;
    tick();
    tick();
    chk("h15_sync_full", 32'(full), 32'h0);
    wr_req = 1'b1;
    #1;
    chk("h15_push_ack", 32'(wr_ack), 32'h1);
    tick();
    chk("h15_push_gray", 32'(wr_gray), 32'h18);
    chk("h15_push_full", 32'(full), 32'h0);
    #1;
    chk("h16_push_ack", 32'(wr_ack), 32'h1);
    tick();
    chk("h16_push_gray", 32'(wr_gray), 32'h19);
    chk("h16_push_full", 32'(full), 32'h1);
    wr_req = 1'b0;

    #1;
    rst_n = 1'b0;
    #1;
    rd_gray_async = 5'b00000;
    rst_n = 1'b1;
    tick();

    // Reader tracking writer across two pointer wraps
    b = 5'd0;
    g = 5'd0;
    for (int i = 0; i < 40; i++) begin
      pg = g;
      rd_gray_async = g;
      wr_req = 1'b1;
      #1;
      chk($sformatf("trk%0d_ack", i), 32'(wr_ack), 32'h1);
      tick();
      b = b + 5'd1;
      g = b ^ (b >> 1);
      chk($sformatf("trk%0d_gray", i), 32'(wr_gray), 32'(g));
      chk($sformatf("trk%0d_step", i), 32'($countones(wr_gray ^ pg)), 32'h1);
      chk($sformatf("trk%0d_addr", i), 32'(wr_addr), 32'(b[3:0]));
      chk($sformatf("trk%0d_full", i), 32'(full), 32'h0);
    end
    wr_req = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
